// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the async FIFO: default widths plus grey/binary
// conversion and popcount, used by the pointer encoder, the receive-side sync and benches.
package fifo_ptr_pkg;

    localparam int PTR_WIDTH_DEF   = 4;
    localparam int SYNC_STAGES_DEF = 2;

    // Operates on 32-bit containers; zero upper bits decode to zero, so callers cast down.
    function automatic logic [31:0] grey2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [31:0] bin2grey(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Generic multi-bit flop chain for carrying a grey pointer across clock domains.
// Stage 0 samples the foreign value directly; no logic sits between stages.
module ptr_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/grey_bin_sync.sv
// Receive side of an async-FIFO pointer: synchronize grey, decode to binary, report advances.
// Optional sticky multi-bit-change checker is built when GREY_SYNC_ERR_CHECK_EN is defined.
module grey_bin_sync
    import fifo_ptr_pkg::*;
#(
    parameter int PTR_WIDTH   = PTR_WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [PTR_WIDTH-1:0] grey_in,
    input  logic                 err_clr,
    output logic [PTR_WIDTH-1:0] grey_sync,
    output logic [PTR_WIDTH-1:0] bin_out,
    output logic                 adv_pulse,
    output logic [PTR_WIDTH-1:0] adv_step,
    output logic                 grey_err
);

    logic [PTR_WIDTH-1:0] w_grey_sync;
    logic [PTR_WIDTH-1:0] w_dec;
    logic [PTR_WIDTH-1:0] r_bin_out;
    logic [PTR_WIDTH-1:0] r_prev_bin;
    logic                 w_adv;

    ptr_sync #(
        .WIDTH  (PTR_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_ptr_sync (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_d     (grey_in),
        .o_q     (w_grey_sync)
    );

    assign w_dec = PTR_WIDTH'(grey2bin(32'(w_grey_sync)));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_bin_out  <= '0;
            r_prev_bin <= '0;
        end else begin
            r_bin_out  <= w_dec;
            r_prev_bin <= r_bin_out;
        end
    end

    // Modular subtraction makes a wrap (e.g. 15 -> 0) a forward step of 1.
    assign w_adv     = (r_bin_out != r_prev_bin);
    assign adv_pulse = w_adv;
    assign adv_step  = w_adv ? (r_bin_out - r_prev_bin) : '0;
    assign bin_out   = r_bin_out;
    assign grey_sync = w_grey_sync;

`ifdef GREY_SYNC_ERR_CHECK_EN
    logic [PTR_WIDTH-1:0] r_prev_grey;
    logic                 r_err;
    int unsigned          w_dist;

    assign w_dist = popcount(32'(w_grey_sync ^ r_prev_grey));

    // A new violation takes priority over a simultaneous clear.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_prev_grey <= '0;
            r_err       <= 1'b0;
        end else begin
            r_prev_grey <= w_grey_sync;
            if (w_dist > 1) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign grey_err = r_err;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign grey_err         = 1'b0;
`endif

endmodule

// File: tb/tb_grey_bin_sync.sv
// Randomized + directed bench for grey_bin_sync against a history-based reference model.
// Expects grey_err activity only when GREY_SYNC_ERR_CHECK_EN is defined for the build.
module tb_grey_bin_sync;

    localparam int W    = 4;
    localparam int S    = 2;
    localparam int MAXC = 8192;
    localparam logic [W-1:0] MASK = '1;

    logic         CLK;
    logic         RST;
    logic [W-1:0] grey_in;
    logic         err_clr;
    logic [W-1:0] grey_sync;
    logic [W-1:0] bin_out;
    logic         adv_pulse;
    logic [W-1:0] adv_step;
    logic         grey_err;

    grey_bin_sync #(.PTR_WIDTH(W), .SYNC_STAGES(S)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .grey_in   (grey_in),
        .err_clr   (err_clr),
        .grey_sync (grey_sync),
        .bin_out   (bin_out),
        .adv_pulse (adv_pulse),
        .adv_step  (adv_step),
        .grey_err  (grey_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int k     = 0;
    int last_rst = -1000;

    // Per-edge history of what was applied and what each output should be afterwards.
    logic [W-1:0] cap_h [MAXC];
    bit           rst_h [MAXC];
    logic [W-1:0] gs_h  [MAXC];
    logic [W-1:0] bin_h [MAXC];
    bit           err_h [MAXC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s edge=%0d got=%0d want=%0d", tag, k, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [W-1:0] ref_b2g(input int unsigned b);
        logic [W-1:0] bb;
        bb = W'(b);
        return bb ^ (bb >> 1);
    endfunction

    function automatic logic [W-1:0] gs_at(input int i);
        return (i < 0) ? '0 : gs_h[i];
    endfunction

    task automatic step(input bit rst_n, input logic [W-1:0] g, input bit clr);
        logic [W-1:0] e_gs, e_bin, e_prev, e_step;
        bit           e_err, viol;
        RST     = rst_n;
        grey_in = g;
        err_clr = clr;
        @(posedge CLK);
        rst_h[k] = !rst_n;
        cap_h[k] = g;
        if (!rst_n) last_rst = k;
        // grey_sync shows the value captured S-1 edges ago unless a reset intervened.
        if (k - S + 1 < 0 || last_rst >= k - S + 1) e_gs = '0;
        else e_gs = cap_h[k-S+1];
        gs_h[k] = e_gs;
        if (!rst_n || k == 0) begin
            e_bin = '0; e_prev = '0; e_err = 1'b0;
        end else begin
            e_bin  = ref_g2b(gs_h[k-1]);
            e_prev = bin_h[k-1];
            viol   = !rst_h[k-1] && ($countones(gs_h[k-1] ^ gs_at(k-2)) > 1);
`ifdef GREY_SYNC_ERR_CHECK_EN
            e_err  = viol || (err_h[k-1] && !clr);
`else
            e_err  = 1'b0 & viol;
`endif
        end
        bin_h[k] = e_bin;
        err_h[k] = e_err;
        e_step   = (e_bin - e_prev) & MASK;
        #1;
        chk("grey_sync", 32'(grey_sync), 32'(e_gs));
        chk("bin_out",   32'(bin_out),   32'(e_bin));
        chk("adv_pulse", 32'(adv_pulse), 32'(e_bin != e_prev));
        chk("adv_step",  32'(adv_step),  32'(e_step));
        chk("grey_err",  32'(grey_err),  32'(e_err));
        k++;
    endtask

    task automatic hold(input logic [W-1:0] g, input int n, input bit clr);
        for (int i = 0; i < n; i++) step(1'b1, g, clr);
    endtask

    int unsigned cur;
    int unsigned r;

    initial begin
        RST = 1'b0; grey_in = '0; err_clr = 1'b0;

        // Reset with a nonzero pointer waiting, then release.
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0110, 1'b0);
        hold(4'b0110, 5, 1'b0);
        chk("t1_bin_final", 32'(bin_out), 32'd4);

        // Full forward sweep including wrap.
        step(1'b0, '0, 1'b0);
        for (int i = 0; i <= 16; i++) hold(ref_b2g(i % 16), 3, 1'b0);
        chk("t2_bin_wrap", 32'(bin_out), 32'd0);

        // Two-step jump from a fast foreign clock.
        hold(4'b0001, 4, 1'b1);
        hold(4'b0010, 4, 1'b0);
        hold(4'b0010, 1, 1'b1);

        // Illegal jump, clear, then clear coinciding with a new violation.
        hold(4'b0000, 4, 1'b0);
        hold(4'b1111, 4, 1'b0);
        chk("t4_bin_illegal", 32'(bin_out), 32'd10);
        hold(4'b1111, 1, 1'b1);
        hold(4'b1111, 2, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        hold(4'b0000, 2, 1'b1);
        hold(4'b0000, 3, 1'b0);

        // Reset while a change is still inside the synchronizer.
        step(1'b1, 4'b0011, 1'b0);
        step(1'b0, 4'b0011, 1'b0);
        hold(4'b0000, 4, 1'b0);

        // Random grey walk with occasional fast steps, illegal jumps, clears and resets.
        cur = 0;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      cur = (cur + 1) % 16;
            else if (r < 70) cur = (cur + $urandom_range(2, 5)) % 16;
            else if (r < 78) cur = $urandom_range(0, 15);
            step(($urandom_range(0, 59) != 0), ref_b2g(cur), ($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
